// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker
//   Exhaustive equivalence checker for two single-output combinational
//   circuits: an original form and a simplified form. On start it steps
//   every minterm 0..2^N_IN-1 onto stim. Each minterm gets one settle cycle
//   (DRIVE) and one compare cycle (SAMPLE). It reports the mismatch count,
//   the first failing minterm and a pass flag.
//   Optional feature macro: TRUTH_TABLE_CAPTURE_EN records f_ref per minterm
//   into tt_out. Without the macro, tt_out is tied to zero.
module minterm_sweep_checker #(
    parameter int N_IN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        stim,
    input  logic                   f_ref,
    input  logic                   f_dut,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_fail,
    output logic [(1<<N_IN)-1:0]   tt_out
);

    localparam int N_MIN = 1 << N_IN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic start_acc;    // start accepted this cycle (IDLE only)
    logic sample_en;    // compare cycle for the current minterm
    logic mism;         // the two circuits disagree on the current minterm
    logic last_min;     // stim is the final minterm of the sweep
    logic fail_seen;    // first_fail has already been captured this sweep

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: walk DRIVE/SAMPLE pairs until the last minterm.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_min ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output and strobe decode from the current state.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        sample_en = 1'b0;
        unique case (state)
            ST_IDLE:   start_acc = start;
            ST_DRIVE:  busy      = 1'b1;
            ST_SAMPLE: begin
                busy      = 1'b1;
                sample_en = 1'b1;
            end
            ST_DONE:   done      = 1'b1;
            default:   ;
        endcase
    end

    assign mism     = f_ref ^ f_dut;
    assign last_min = (stim == N_IN'(N_MIN - 1));

    // Sweep datapath: minterm counter, mismatch tally, first-failure capture, pass flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim         <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_seen    <= 1'b0;
            pass         <= 1'b0;
        end else if (start_acc) begin
            stim         <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_seen    <= 1'b0;
            pass         <= 1'b0;
        end else if (sample_en) begin
            // The counter is one bit wider than stim, so even an all-minterm
            // mismatch (2^N_IN) fits without wrapping.
            if (mism) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (!fail_seen) begin
                    first_fail <= stim;
                    fail_seen  <= 1'b1;
                end
            end
            // stim parks on the last minterm after the sweep.
            if (!last_min) stim <= stim + 1'b1;
        end else if (done) begin
            pass <= (mismatch_cnt == '0);
        end
    end

`ifdef TRUTH_TABLE_CAPTURE_EN
    logic [N_MIN-1:0] tt_q;

    // Truth-table capture of the original circuit, one bit per minterm.
    always_ff @(posedge clk) begin
        // NOTE: this per-minterm storage is cleared on reset and on start on
        // purpose. tt_out must read all-zero until a sweep fills it.
        if (!rst_n)         tt_q       <= '0;
        else if (start_acc) tt_q       <= '0;
        else if (sample_en) tt_q[stim] <= f_ref;
    end

    assign tt_out = tt_q;
`else
    assign tt_out = '0;
`endif

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Self-checking bench for minterm_sweep_checker (N_IN = 3, stim = {A,B,C}).
// Both circuits are modelled as truth tables indexed by stim. Expected sweep
// results come from hand-derived vectors and from a queue-based model.
module tb_minterm_sweep_checker;

    localparam int N_IN = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] stim;
    logic       f_ref, f_dut;
    logic       busy, done, pass;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail;
    logic [7:0] tt_out;

    logic [7:0] ref_tt, dut_tt;

    int n_cmp  = 0;
    int n_fail = 0;

    minterm_sweep_checker #(.N_IN(N_IN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stim         (stim),
        .f_ref        (f_ref),
        .f_dut        (f_dut),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .tt_out       (tt_out)
    );

    always #5 clk = ~clk;

    assign f_ref = ref_tt[stim];
    assign f_dut = dut_tt[stim];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Circuit kinds: 0 AB|AB'C, 1 A(B|C), 2 AB, 3 ~(AB|AB'C)
    function automatic logic [7:0] build_tt(input int kind);
        logic [7:0] t;
        bit a, b, c, f;
        t = '0;
        for (int m = 0; m < 8; m++) begin
            a = m[2]; b = m[1]; c = m[0];
            case (kind)
                0:       f = (a & b) | (a & ~b & c);
                1:       f = a & (b | c);
                2:       f = a & b;
                default: f = ~((a & b) | (a & ~b & c));
            endcase
            t[m] = f;
        end
        return t;
    endfunction

    function automatic logic [7:0] exp_tt(input logic [7:0] r);
`ifdef TRUTH_TABLE_CAPTURE_EN
        return r;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " stim"}, stim, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " cnt"}, mismatch_cnt, 0);
        check({tag, " first"}, first_fail, 0);
        check({tag, " tt"}, tt_out, 0);
    endtask

    // Call at a negedge with the DUT idle. Returns at the negedge after done.
    task automatic sweep(input string tag, input bit hold, input bit extra,
                         output int dc, output logic [3:0] cnt, output logic [2:0] ff,
                         output logic [7:0] tt, output logic p);
        start = 1'b1;
        @(posedge clk);
        dc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = hold || (extra && (k == 3 || k == 9));
            if (k == 1) begin
                check({tag, " busy@1"}, busy, 1);
                check({tag, " stim@1"}, stim, 0);
            end
            if (done) begin
                dc = k;
                break;
            end
        end
        cnt = mismatch_cnt;
        ff  = first_fail;
        tt  = tt_out;
        @(negedge clk);
        p = pass;
        check({tag, " done_1cyc"}, done, 0);
        check({tag, " stim_hold"}, stim, 7);
    endtask

    typedef struct {
        string      name;
        int         ref_kind;
        int         dut_kind;
        bit         extra;
        int         exp_cnt;
        int         exp_first;
        bit         exp_pass;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int         dc;
        logic [3:0] cnt;
        logic [2:0] ff;
        logic [7:0] tt;
        logic       p;

        vecs[0] = '{"equiv",      0, 1, 1'b0, 0, 0, 1'b1};
        vecs[1] = '{"faulty_ab",  0, 2, 1'b0, 1, 5, 1'b0};
        vecs[2] = '{"full_inv",   0, 3, 1'b0, 8, 0, 1'b0};
        vecs[3] = '{"busy_start", 0, 1, 1'b1, 0, 0, 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        ref_tt = '0;
        dut_tt = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven scenarios 1-4
        for (int i = 0; i < 4; i++) begin
            ref_tt = build_tt(vecs[i].ref_kind);
            dut_tt = build_tt(vecs[i].dut_kind);
            sweep(vecs[i].name, 1'b0, vecs[i].extra, dc, cnt, ff, tt, p);
            check({vecs[i].name, " latency"}, dc, 17);
            check({vecs[i].name, " cnt"}, cnt, vecs[i].exp_cnt);
            check({vecs[i].name, " first"}, ff, vecs[i].exp_first);
            check({vecs[i].name, " pass"}, p, vecs[i].exp_pass);
            check({vecs[i].name, " tt"}, tt, exp_tt(8'hE0));
        end

        // Scenario 5: reset in cycle 8 of a fully mismatching sweep
        ref_tt = build_tt(0);
        dut_tt = build_tt(3);
        start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midreset cnt@8", mismatch_cnt, 3);
        check("midreset busy@8", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("midreset");
        @(negedge clk);
        check("midreset idle", busy, 0);
        dut_tt = build_tt(2);
        sweep("after_reset", 1'b0, 1'b0, dc, cnt, ff, tt, p);
        check("after_reset latency", dc, 17);
        check("after_reset cnt", cnt, 1);
        check("after_reset first", ff, 5);
        check("after_reset pass", p, 0);

        // Scenario 6: back-to-back sweeps with start held high
        dut_tt = build_tt(2);
        sweep("b2b_first", 1'b1, 1'b0, dc, cnt, ff, tt, p);
        check("b2b_first cnt", cnt, 1);
        check("b2b_first first", ff, 5);
        check("b2b_first pass", p, 0);
        dut_tt = build_tt(1);
        sweep("b2b_second", 1'b1, 1'b0, dc, cnt, ff, tt, p);
        start = 1'b0;
        check("b2b_second latency", dc, 17);
        check("b2b_second cnt", cnt, 0);
        check("b2b_second first", ff, 0);
        check("b2b_second pass", p, 1);
        @(negedge clk);

        // Randomized circuit pairs against a queue-based model
        for (int r = 0; r < 8; r++) begin
            int q[$];
            ref_tt = 8'($urandom);
            if ($urandom_range(0, 1) == 1) dut_tt = ref_tt ^ (8'($urandom) & 8'($urandom));
            else                           dut_tt = 8'($urandom);
            q = {};
            for (int m = 0; m < 8; m++)
                if (ref_tt[m] != dut_tt[m]) q.push_back(m);
            sweep($sformatf("rand%0d", r), 1'b0, 1'b0, dc, cnt, ff, tt, p);
            check($sformatf("rand%0d latency", r), dc, 17);
            check($sformatf("rand%0d cnt", r), cnt, q.size());
            check($sformatf("rand%0d first", r), ff, (q.size() > 0) ? q[0] : 0);
            check($sformatf("rand%0d pass", r), p, (q.size() == 0) ? 1 : 0);
            check($sformatf("rand%0d tt", r), tt, exp_tt(ref_tt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
